// File: rtl/ppa_fetch1_ftq.sv
`default_nettype none
// ============================================================================
// Module      : ppa_fetch1_ftq
// Description : Decoupled fetch-target queue for fetch stage 1. A generation
//               PC (genPC) walks ahead of the I-cache. Each cycle it forms one
//               fetch block (block PC + lane-valid mask) from the BTB/RAS/bpred
//               prediction and pushes that block into a DEPTH-entry FIFO. The
//               FIFO head is presented to the I-cache. Redirects flush the
//               queue and reload genPC. The priority order is reset,
//               resetFetch, exception, recover, fs2Recover.
// Ports       : clk, reset             clock, synchronous active-high reset
//               resetFetch_i/startPC_i flush and reload genPC from startPC_i
//               exception/recover/fs2Recover Flag_i + PC_i  redirect sources
//               predPC_o               genPC, indexes the predictors
//               predTaken_i/predLane_i/predTarget_i  prediction for predPC_o
//               stall_i                back-pressure, blocks dequeue only
//               fetchReq_o/fetchPC_o/fetchMask_o  head block to the I-cache
//               fetchAck_i             I-cache accept, pops head on request
//               occupancy_o            number of valid entries
//               perfRedirectCnt_o/perfFullCnt_o  only when FTQ_PERF_EN is
//                                      defined
// Config      : FTQ_PERF_EN (optional saturating performance counters)
// Revision    : 1.0 - initial release
// ============================================================================
module ppa_fetch1_ftq #(
  parameter int FETCH_WIDTH = 4,
  parameter int DEPTH       = 8,
  parameter int SIZE_PC     = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             resetFetch_i,
  input  logic [SIZE_PC-1:0]               startPC_i,
  input  logic                             exceptionFlag_i,
  input  logic [SIZE_PC-1:0]               exceptionPC_i,
  input  logic                             recoverFlag_i,
  input  logic [SIZE_PC-1:0]               recoverPC_i,
  input  logic                             fs2RecoverFlag_i,
  input  logic [SIZE_PC-1:0]               fs2RecoverPC_i,
  output logic [SIZE_PC-1:0]               predPC_o,
  input  logic                             predTaken_i,
  input  logic [$clog2(FETCH_WIDTH)-1:0]   predLane_i,
  input  logic [SIZE_PC-1:0]               predTarget_i,
  input  logic                             stall_i,
  output logic                             fetchReq_o,
  output logic [SIZE_PC-1:0]               fetchPC_o,
  output logic [FETCH_WIDTH-1:0]           fetchMask_o,
  input  logic                             fetchAck_i,
  output logic [$clog2(DEPTH):0]           occupancy_o
`ifdef FTQ_PERF_EN
  ,
  output logic [31:0]                      perfRedirectCnt_o,
  output logic [31:0]                      perfFullCnt_o
`endif
);

  localparam int c_LANE_W      = $clog2(FETCH_WIDTH);
  localparam int c_PTR_W       = $clog2(DEPTH);
  localparam int c_CNT_W       = c_PTR_W + 1;
  localparam int c_BLOCK_BYTES = FETCH_WIDTH * 4;

  // Queue storage and state
  logic [SIZE_PC-1:0]     r_pcMem   [DEPTH];
  logic [FETCH_WIDTH-1:0] r_maskMem [DEPTH];
  logic [c_PTR_W-1:0]     r_head;
  logic [c_PTR_W-1:0]     r_tail;
  logic [c_CNT_W-1:0]     r_count;
  logic [SIZE_PC-1:0]     r_genPC;

  logic                   w_redirect;
  logic [SIZE_PC-1:0]     w_redirectPC;
  logic [c_LANE_W-1:0]    w_off;
  logic                   w_takenEff;
  logic [FETCH_WIDTH-1:0] w_mask;
  logic [SIZE_PC-1:0]     w_base;
  logic [SIZE_PC-1:0]     w_nextPC;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;

  // ---------------------------------------------------------------------------
  // Redirect arbitration. The full reset is handled separately in the
  // sequential block because it also clears the performance counters.
  // ---------------------------------------------------------------------------
  assign w_redirect = resetFetch_i | exceptionFlag_i | recoverFlag_i | fs2RecoverFlag_i;

  always_comb begin
    w_redirectPC = fs2RecoverPC_i;
    if (resetFetch_i)          w_redirectPC = startPC_i;
    else if (exceptionFlag_i)  w_redirectPC = exceptionPC_i;
    else if (recoverFlag_i)    w_redirectPC = recoverPC_i;
  end

  // ---------------------------------------------------------------------------
  // Fetch-block geometry. Lanes below the entry offset are not part of the
  // block. Lanes past the first taken CTI are also excluded. A taken lane that
  // lies before the entry offset cannot be reached, so that prediction is
  // treated as not taken.
  // ---------------------------------------------------------------------------
  assign w_off      = r_genPC[c_LANE_W+1:2];
  assign w_takenEff = predTaken_i & (predLane_i >= w_off);
  assign w_base     = {r_genPC[SIZE_PC-1:c_LANE_W+2], {(c_LANE_W+2){1'b0}}};
  assign w_nextPC   = w_takenEff ? predTarget_i : (w_base + SIZE_PC'(c_BLOCK_BYTES));

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_mask[i] = (c_LANE_W'(i) >= w_off) & (~w_takenEff | (c_LANE_W'(i) <= predLane_i));
    end
  end

  // ---------------------------------------------------------------------------
  // Queue control. A full queue never enqueues, even when the head pops in
  // the same cycle, so the full/push path has no combinational pass-through.
  // ---------------------------------------------------------------------------
  assign w_full  = (r_count == c_CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = ~w_full & ~w_redirect;
  assign w_pop   = fetchReq_o & fetchAck_i;

  assign fetchReq_o  = ~w_empty & ~stall_i & ~w_redirect;
  assign fetchPC_o   = w_empty ? '0 : r_pcMem[r_head];
  assign fetchMask_o = w_empty ? '0 : r_maskMem[r_head];
  assign occupancy_o = r_count;
  assign predPC_o    = r_genPC;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_genPC <= startPC_i;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_redirect) begin
      r_genPC <= w_redirectPC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_genPC <= w_nextPC;
        r_tail  <= r_tail + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The entry payload needs no reset. Entries are only read while they are
  // counted as valid.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_pcMem[r_tail]   <= r_genPC;
      r_maskMem[r_tail] <= w_mask;
    end
  end

`ifdef FTQ_PERF_EN
  // Saturating event counters. They are cleared by the full reset only, so
  // they survive resetFetch_i.
  logic [31:0] r_perfRedirectCnt;
  logic [31:0] r_perfFullCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perfRedirectCnt <= '0;
      r_perfFullCnt     <= '0;
    end else begin
      if (w_redirect && (r_perfRedirectCnt != 32'hFFFF_FFFF)) begin
        r_perfRedirectCnt <= r_perfRedirectCnt + 32'd1;
      end
      if (w_full && (r_perfFullCnt != 32'hFFFF_FFFF)) begin
        r_perfFullCnt <= r_perfFullCnt + 32'd1;
      end
    end
  end

  assign perfRedirectCnt_o = r_perfRedirectCnt;
  assign perfFullCnt_o     = r_perfFullCnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ppa_fetch1_ftq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppa_fetch1_ftq
// Description : Self-checking bench for ppa_fetch1_ftq with FETCH_WIDTH=4 and
//               DEPTH=8. It has three parts:
//               - a per-cycle vector table with {inputs, expected outputs};
//               - a scoreboard of expected fetch PCs, used for the
//                 miss/saturation sequence;
//               - a hand-written sequence with simultaneous redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppa_fetch1_ftq;

  logic        clk = 1'b0;
  logic        reset;
  logic        resetFetch_i;
  logic [31:0] startPC_i;
  logic        exceptionFlag_i;
  logic [31:0] exceptionPC_i;
  logic        recoverFlag_i;
  logic [31:0] recoverPC_i;
  logic        fs2RecoverFlag_i;
  logic [31:0] fs2RecoverPC_i;
  logic [31:0] predPC_o;
  logic        predTaken_i;
  logic [1:0]  predLane_i;
  logic [31:0] predTarget_i;
  logic        stall_i;
  logic        fetchReq_o;
  logic [31:0] fetchPC_o;
  logic [3:0]  fetchMask_o;
  logic        fetchAck_i;
  logic [3:0]  occupancy_o;
`ifdef FTQ_PERF_EN
  logic [31:0] perfRedirectCnt_o;
  logic [31:0] perfFullCnt_o;
`endif

  ppa_fetch1_ftq #(.FETCH_WIDTH(4), .DEPTH(8), .SIZE_PC(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .resetFetch_i     (resetFetch_i),
    .startPC_i        (startPC_i),
    .exceptionFlag_i  (exceptionFlag_i),
    .exceptionPC_i    (exceptionPC_i),
    .recoverFlag_i    (recoverFlag_i),
    .recoverPC_i      (recoverPC_i),
    .fs2RecoverFlag_i (fs2RecoverFlag_i),
    .fs2RecoverPC_i   (fs2RecoverPC_i),
    .predPC_o         (predPC_o),
    .predTaken_i      (predTaken_i),
    .predLane_i       (predLane_i),
    .predTarget_i     (predTarget_i),
    .stall_i          (stall_i),
    .fetchReq_o       (fetchReq_o),
    .fetchPC_o        (fetchPC_o),
    .fetchMask_o      (fetchMask_o),
    .fetchAck_i       (fetchAck_i),
    .occupancy_o      (occupancy_o)
`ifdef FTQ_PERF_EN
    ,
    .perfRedirectCnt_o(perfRedirectCnt_o),
    .perfFullCnt_o    (perfFullCnt_o)
`endif
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nBad = 0;

  typedef struct {
    logic [4:0]  ctl;      // {reset, resetFetch, exception, recover, fs2Recover}
    logic [31:0] redirPC;  // driven on all three redirect PC inputs
    logic        taken;
    logic [1:0]  lane;
    logic [31:0] target;
    logic        stall;
    logic        chk;
    logic        expReq;
    logic [31:0] expPC;
    logic [3:0]  expMask;
    logic [3:0]  expOcc;
    logic [31:0] expPred;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mkv(logic [4:0] ctl, logic [31:0] rpc, logic tk, logic [1:0] ln,
                               logic [31:0] tg, logic st, logic ck, logic rq, logic [31:0] pc,
                               logic [3:0] mk, logic [3:0] oc, logic [31:0] pp);
    vec_t v;
    v.ctl = ctl; v.redirPC = rpc; v.taken = tk; v.lane = ln; v.target = tg; v.stall = st;
    v.chk = ck; v.expReq = rq; v.expPC = pc; v.expMask = mk; v.expOcc = oc; v.expPred = pp;
    return v;
  endfunction

  task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; resetFetch_i = 1'b0; exceptionFlag_i = 1'b0; recoverFlag_i = 1'b0;
    fs2RecoverFlag_i = 1'b0; predTaken_i = 1'b0; predLane_i = 2'd0; predTarget_i = 32'h0;
    stall_i = 1'b0; fetchAck_i = 1'b1; startPC_i = 32'h1000;
    exceptionPC_i = 32'h0; recoverPC_i = 32'h0; fs2RecoverPC_i = 32'h0;
  endtask

  // Advance to just after the next rising edge so that inputs can be changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sbQ[$];
  logic [31:0] expPC;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    reset = 1'b1;

    // --------------------------------------------------------------------
    // Vector table: each row gives the inputs for one cycle. The outputs are
    // checked on the falling edge of the same cycle.
    // --------------------------------------------------------------------
    vecs[0]  = mkv(5'b10000, 32'h0,       0,0,32'h0,    0, 0, 0,32'h0,       4'h0,4'd0,32'h0);
    vecs[1]  = mkv(5'b00000, 32'h0,       0,0,32'h0,    0, 1, 0,32'h0,       4'h0,4'd0,32'h1000);
    vecs[2]  = mkv(5'b00000, 32'h0,       0,0,32'h0,    0, 1, 1,32'h1000,    4'hF,4'd1,32'h1010);
    vecs[3]  = mkv(5'b00000, 32'h0,       0,0,32'h0,    0, 1, 1,32'h1010,    4'hF,4'd1,32'h1020);
    vecs[4]  = mkv(5'b00000, 32'h0,       0,0,32'h0,    0, 1, 1,32'h1020,    4'hF,4'd1,32'h1030);
    vecs[5]  = mkv(5'b00010, 32'h1008,    0,0,32'h0,    0, 1, 0,32'h1030,    4'hF,4'd1,32'h1040);
    vecs[6]  = mkv(5'b00000, 32'h0,       0,0,32'h0,    0, 1, 0,32'h0,       4'h0,4'd0,32'h1008);
    vecs[7]  = mkv(5'b00000, 32'h0,       0,0,32'h0,    0, 1, 1,32'h1008,    4'hC,4'd1,32'h1010);
    vecs[8]  = mkv(5'b00000, 32'h0,       0,0,32'h0,    0, 1, 1,32'h1010,    4'hF,4'd1,32'h1020);
    vecs[9]  = mkv(5'b00001, 32'h2000,    0,0,32'h0,    0, 1, 0,32'h1020,    4'hF,4'd1,32'h1030);
    vecs[10] = mkv(5'b00000, 32'h0,       1,1,32'h3004, 0, 1, 0,32'h0,       4'h0,4'd0,32'h2000);
    vecs[11] = mkv(5'b00000, 32'h0,       1,0,32'h5000, 0, 1, 1,32'h2000,    4'h3,4'd1,32'h3004);
    vecs[12] = mkv(5'b00000, 32'h0,       1,3,32'h4000, 0, 1, 1,32'h3004,    4'hE,4'd1,32'h3010);
    vecs[13] = mkv(5'b00000, 32'h0,       0,0,32'h0,    0, 1, 1,32'h3010,    4'hF,4'd1,32'h4000);
    vecs[14] = mkv(5'b00000, 32'h0,       0,0,32'h0,    0, 1, 1,32'h4000,    4'hF,4'd1,32'h4010);
    vecs[15] = mkv(5'b01100, 32'h80,      0,0,32'h0,    0, 1, 0,32'h4010,    4'hF,4'd1,32'h4020);
    vecs[16] = mkv(5'b00000, 32'h0,       0,0,32'h0,    0, 1, 0,32'h0,       4'h0,4'd0,32'h1000);
    vecs[17] = mkv(5'b00000, 32'h0,       0,0,32'h0,    0, 1, 1,32'h1000,    4'hF,4'd1,32'h1010);
    vecs[18] = mkv(5'b00000, 32'h0,       0,0,32'h0,    1, 1, 0,32'h1010,    4'hF,4'd1,32'h1020);
    vecs[19] = mkv(5'b00000, 32'h0,       0,0,32'h0,    0, 1, 1,32'h1010,    4'hF,4'd2,32'h1030);
    vecs[20] = mkv(5'b00000, 32'h0,       0,0,32'h0,    0, 1, 1,32'h1020,    4'hF,4'd2,32'h1040);
    vecs[21] = mkv(5'b00001, 32'hFFFFFFF8,0,0,32'h0,    0, 1, 0,32'h1030,    4'hF,4'd2,32'h1050);
    vecs[22] = mkv(5'b00000, 32'h0,       0,0,32'h0,    0, 1, 0,32'h0,       4'h0,4'd0,32'hFFFFFFF8);
    vecs[23] = mkv(5'b00000, 32'h0,       0,0,32'h0,    0, 1, 1,32'hFFFFFFF8,4'hC,4'd1,32'h0);
    vecs[24] = mkv(5'b00000, 32'h0,       0,0,32'h0,    0, 1, 1,32'h0,       4'hF,4'd1,32'h10);

    for (int i = 0; i < 25; i++) begin
      tick();
      idle();
      {reset, resetFetch_i, exceptionFlag_i, recoverFlag_i, fs2RecoverFlag_i} = vecs[i].ctl;
      exceptionPC_i = vecs[i].redirPC;
      recoverPC_i = vecs[i].redirPC;
      fs2RecoverPC_i = vecs[i].redirPC;
      predTaken_i = vecs[i].taken;
      predLane_i = vecs[i].lane;
      predTarget_i = vecs[i].target;
      stall_i = vecs[i].stall;
      @(negedge clk);
      if (vecs[i].chk) begin
        check($sformatf("row%0d {req,pc,mask,occ,predPC}", i),
              {55'd0, fetchReq_o, fetchPC_o, fetchMask_o, occupancy_o, predPC_o},
              {55'd0, vecs[i].expReq, vecs[i].expPC, vecs[i].expMask, vecs[i].expOcc, vecs[i].expPred});
      end
    end

    // --------------------------------------------------------------------
    // I-cache miss: ack held low for 12 cycles, so the queue saturates at 8
    // with the head held. The drain is then checked against the scoreboard.
    // --------------------------------------------------------------------
    tick(); idle(); reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(); idle(); fetchAck_i = 1'b0;
      @(negedge clk);
      check($sformatf("miss c%0d occupancy", k), {124'd0, occupancy_o},
            {124'd0, (k - 1 > 8) ? 4'd8 : 4'(k - 1)});
      if (k >= 2)
        check($sformatf("miss c%0d head held", k), {91'd0, fetchReq_o, fetchPC_o, fetchMask_o},
              {91'd0, 1'b1, 32'h1000, 4'hF});
    end
    for (int j = 0; j < 16; j++) sbQ.push_back(32'h1000 + 32'(j) * 32'h10);
    for (int b = 0; b < 40 && sbQ.size() != 0; b++) begin
      tick(); idle();
      @(negedge clk);
      if (fetchReq_o && fetchAck_i) begin
        expPC = sbQ.pop_front();
        check("drain fetch", {92'd0, fetchPC_o, fetchMask_o}, {92'd0, expPC, 4'hF});
      end
    end
    check("drain complete", {96'd0, 32'(sbQ.size())}, 128'd0);
`ifdef FTQ_PERF_EN
    check("perfFullCnt after miss", {96'd0, perfFullCnt_o}, {96'd0, 32'd5});
    check("perfRedirectCnt after miss", {96'd0, perfRedirectCnt_o}, 128'd0);
`endif
    // A stall keeps the head in place and suppresses the request.
    for (int k = 0; k < 4; k++) begin
      tick(); idle(); stall_i = 1'b1;
      @(negedge clk);
      check($sformatf("stall c%0d", k), {95'd0, fetchReq_o, fetchPC_o},
            {95'd0, 1'b0, 32'h1100});
    end

    // --------------------------------------------------------------------
    // Three simultaneous redirects with 5 entries queued. The exception
    // redirect has the highest priority of the three and must win.
    // --------------------------------------------------------------------
    tick(); idle(); reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(); idle(); fetchAck_i = 1'b0;
    end
    tick(); idle(); fetchAck_i = 1'b0;
    exceptionFlag_i = 1'b1; exceptionPC_i = 32'h80;
    recoverFlag_i = 1'b1; recoverPC_i = 32'h500;
    fs2RecoverFlag_i = 1'b1; fs2RecoverPC_i = 32'h900;
    @(negedge clk);
    check("multi-redirect cycle {req,occ}", {123'd0, fetchReq_o, occupancy_o},
          {123'd0, 1'b0, 4'd5});
    tick(); idle(); fetchAck_i = 1'b0;
    @(negedge clk);
    check("post-redirect {occ,predPC}", {92'd0, occupancy_o, predPC_o}, {92'd0, 4'd0, 32'h80});
    tick(); idle(); fetchAck_i = 1'b0;
    @(negedge clk);
    check("redirected head {req,pc,mask}", {91'd0, fetchReq_o, fetchPC_o, fetchMask_o},
          {91'd0, 1'b1, 32'h80, 4'hF});
`ifdef FTQ_PERF_EN
    check("perfRedirectCnt", {96'd0, perfRedirectCnt_o}, {96'd0, 32'd1});
    check("perfFullCnt cleared", {96'd0, perfFullCnt_o}, 128'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
`default_nettype wire
